regfile_mp_sb: RTL and testbench

- Parametrised multi-port integer register file with an integrated write-pending scoreboard; successor to the single-read-pair/single-write register file in the decode/writeback path.
- Provides NUM_RD combinational read ports with same-cycle write bypass, and NUM_WR write ports with fixed priority.
- Tracks outstanding writes per architectural register with saturating in-flight counters, so issue logic can stall on RAW/WAW hazards.
- Register 0 is hardwired to zero and is never busy.

---
 rtl/regfile_pkg.sv | 39 +++
 rtl/regfile_mp_sb_counter.sv | 46 ++++
 rtl/regfile_mp_sb.sv | 156 +++++++++++++++
 tb/tb_regfile_mp_sb.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file and its scoreboard.
//   XLEN_DEFAULT / NREG_DEFAULT : default data width and register count
//   ZERO_XLEN                   : all-zero data word
//   addrWidth()                 : register-index width for a given register count
//   highestMatch()              : write-port priority select (highest index wins)
package regfile_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;
    localparam int unsigned NREG_DEFAULT = 32;

    localparam logic [XLEN_DEFAULT-1:0] ZERO_XLEN = '0;

    // Upper bound on write ports handled by the priority helper.
    localparam int unsigned MAX_WR   = 16;
    localparam int unsigned WR_IDX_W = 4;

    typedef struct packed {
        logic                hit;
        logic [WR_IDX_W-1:0] idx;
    } wrSel_t;

    function automatic int unsigned addrWidth(input int unsigned nReg);
        return (nReg < 2) ? 1 : $clog2(nReg);
    endfunction

    // Returns the highest-index set bit of matchVec, if any.
    function automatic wrSel_t highestMatch(input logic [MAX_WR-1:0] matchVec);
        wrSel_t sel;
        sel = '0;
        for (int unsigned i = 0; i < MAX_WR; i++) begin
            if (matchVec[i]) begin
                sel.hit = 1'b1;
                sel.idx = i[WR_IDX_W-1:0];
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_mp_sb_counter.sv
// Single in-flight write counter for one architectural register.
//   clk, rst   : clock, synchronous active-high reset
//   inc        : one reservation accepted this cycle
//   decCount   : number of retiring writes to this register this cycle
//   cnt        : current outstanding-write count
//   underflow  : this cycle's clears exceed cnt+inc (counter is forced to 0)
module sb_counter #(
    parameter int unsigned CNT_W = 2,
    parameter int unsigned DEC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic [DEC_W-1:0] decCount,
    output logic [CNT_W-1:0] cnt,
    output logic             underflow
);

    localparam int unsigned SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;
    localparam logic [SUM_W-1:0] MAX_CNT = SUM_W'((1 << CNT_W) - 1);

    logic [SUM_W-1:0] avail;
    logic [CNT_W-1:0] cntNext;

    always_comb begin
        avail     = SUM_W'(cnt) + SUM_W'(inc);
        underflow = SUM_W'(decCount) > avail;
        cntNext   = '0;
        if (!underflow) begin
            if ((avail - SUM_W'(decCount)) > MAX_CNT) begin
                cntNext = '1;
            end else begin
                cntNext = CNT_W'(avail - SUM_W'(decCount));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cntNext;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-pending scoreboard.
//   clk, rst       : clock, synchronous active-high reset
//   ren/raddr      : NUM_RD read ports (port j at raddr[j*AW +: AW])
//   rdata          : combinational read data with same-cycle write bypass
//   rbusy          : register still has outstanding writes after this cycle's clears
//   we/waddr/wdata : NUM_WR write ports, highest index wins on collision
//   wclr           : a write also retires one scoreboard entry for its address
//   issue_valid/issue_addr/issue_ready : destination reservation handshake
//   err_underflow  : sticky, a clear hit a counter already at zero
// Register 0 reads as zero and is never busy. NUM_WR must not exceed MAX_WR.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN   = XLEN_DEFAULT,
    parameter  int unsigned NREG   = NREG_DEFAULT,
    parameter  int unsigned NUM_RD = 2,
    parameter  int unsigned NUM_WR = 2,
    parameter  int unsigned CNT_W  = 2,
    localparam int unsigned AW     = addrWidth(NREG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD-1:0]      ren,
    input  logic [NUM_RD*AW-1:0]   raddr,
    output logic [NUM_RD*XLEN-1:0] rdata,
    output logic [NUM_RD-1:0]      rbusy,
    input  logic [NUM_WR-1:0]      we,
    input  logic [NUM_WR*AW-1:0]   waddr,
    input  logic [NUM_WR*XLEN-1:0] wdata,
    input  logic [NUM_WR-1:0]      wclr,
    input  logic                   issue_valid,
    input  logic [AW-1:0]          issue_addr,
    output logic                   issue_ready,
    output logic                   err_underflow
);

    localparam int unsigned DEC_W = $clog2(NUM_WR + 1);
    localparam int unsigned CMP_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;
    localparam logic [CMP_W-1:0] CNT_MAX = CMP_W'((1 << CNT_W) - 1);

    logic [XLEN-1:0]  regs     [NREG];
    logic [AW-1:0]    wAddrArr [NUM_WR];
    logic [XLEN-1:0]  wDataArr [NUM_WR];
    logic [AW-1:0]    rAddrArr [NUM_RD];
    logic [CNT_W-1:0] cntArr   [NREG];
    logic [DEC_W-1:0] decArr   [NREG];
    logic [NREG-1:1]  incVec;
    logic [NREG-1:1]  ufVec;

    always_comb begin
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            wAddrArr[i] = waddr[i*AW +: AW];
            wDataArr[i] = wdata[i*XLEN +: XLEN];
        end
        for (int unsigned j = 0; j < NUM_RD; j++) begin
            rAddrArr[j] = raddr[j*AW +: AW];
        end
    end

    // Same-cycle retire count per register; wclr without we is ignored.
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            decArr[r] = '0;
            for (int unsigned i = 0; i < NUM_WR; i++) begin
                if (we[i] && wclr[i] && (wAddrArr[i] == r[AW-1:0])) begin
                    decArr[r] = decArr[r] + DEC_W'(1);
                end
            end
        end
    end

    // Data array: later loop iterations override earlier ones, so the
    // highest-index port wins on an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs[r] <= XLEN'(ZERO_XLEN);
            end
        end else begin
            for (int unsigned i = 0; i < NUM_WR; i++) begin
                if (we[i] && (wAddrArr[i] != '0)) begin
                    regs[wAddrArr[i]] <= wDataArr[i];
                end
            end
        end
    end

    // Read ports with bypass and busy lookup.
    always_comb begin : readMux
        logic [AW-1:0]     addr;
        logic [MAX_WR-1:0] matchVec;
        wrSel_t            sel;
        logic [XLEN-1:0]   rd;
        addr     = '0;
        matchVec = '0;
        sel      = '0;
        rd       = '0;
        rdata    = '0;
        rbusy    = '0;
        for (int unsigned j = 0; j < NUM_RD; j++) begin
            addr = rAddrArr[j];
            if (!rst && ren[j] && (addr != '0)) begin
                matchVec = '0;
                for (int unsigned i = 0; i < NUM_WR; i++) begin
                    matchVec[i] = we[i] && (wAddrArr[i] == addr);
                end
                sel = highestMatch(matchVec);
                rd  = regs[addr];
                for (int unsigned i = 0; i < NUM_WR; i++) begin
                    if (sel.hit && (sel.idx == i[WR_IDX_W-1:0])) begin
                        rd = wDataArr[i];
                    end
                end
                rdata[j*XLEN +: XLEN] = rd;
                rbusy[j] = CMP_W'(cntArr[addr]) > CMP_W'(decArr[addr]);
            end
        end
    end

    // cnt - dec < MAX rewritten as cnt < MAX + dec to stay unsigned; a clear
    // exceeding the count still frees the slot.
    always_comb begin
        issue_ready = !rst &&
                      ((issue_addr == '0) ||
                       (CMP_W'(cntArr[issue_addr]) < (CNT_MAX + CMP_W'(decArr[issue_addr]))));
    end

    assign cntArr[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : gCnt
        localparam logic [AW-1:0] REG_ADDR = AW'(r);

        assign incVec[r] = issue_valid && issue_ready && (issue_addr == REG_ADDR);

        sb_counter #(
            .CNT_W(CNT_W),
            .DEC_W(DEC_W)
        ) uCnt (
            .clk      (clk),
            .rst      (rst),
            .inc      (incVec[r]),
            .decCount (decArr[r]),
            .cnt      (cntArr[r]),
            .underflow(ufVec[r])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_underflow <= 1'b0;
        end else if (|ufVec) begin
            err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;

    logic         clk;
    logic         rst;
    logic [1:0]   ren;
    logic [4:0]   ra0, ra1;
    logic [127:0] rdata;
    logic [1:0]   rbusy;
    logic [1:0]   we;
    logic [4:0]   wa0, wa1;
    logic [63:0]  wd0, wd1;
    logic [1:0]   wclr;
    logic         issue_valid;
    logic [4:0]   issue_addr;
    logic         issue_ready;
    logic         err_underflow;

    int nChecks = 0;
    int nFails  = 0;

    regfile_mp_sb #(
        .XLEN  (64),
        .NREG  (32),
        .NUM_RD(2),
        .NUM_WR(2),
        .CNT_W (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ren          (ren),
        .raddr        ({ra1, ra0}),
        .rdata        (rdata),
        .rbusy        (rbusy),
        .we           (we),
        .waddr        ({wa1, wa0}),
        .wdata        ({wd1, wd0}),
        .wclr         (wclr),
        .issue_valid  (issue_valid),
        .issue_addr   (issue_addr),
        .issue_ready  (issue_ready),
        .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [63:0] wd0, wd1;
        logic [1:0]  wclr;
        logic [1:0]  ren;
        logic [4:0]  ra0, ra1;
        logic        iv;
        logic [4:0]  ia;
        logic [63:0] e0, e1;
        logic [1:0]  eBusy;
        logic        eReady;
    } vec_t;

    function automatic vec_t mk(
        input logic rs, input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
        input logic [63:0] d0, input logic [63:0] d1, input logic [1:0] c, input logic [1:0] re,
        input logic [4:0] r0, input logic [4:0] r1, input logic v, input logic [4:0] ia,
        input logic [63:0] x0, input logic [63:0] x1, input logic [1:0] b, input logic rdy);
        vec_t t;
        t.rst = rs; t.we = w; t.wa0 = a0; t.wa1 = a1; t.wd0 = d0; t.wd1 = d1;
        t.wclr = c; t.ren = re; t.ra0 = r0; t.ra1 = r1; t.iv = v; t.ia = ia;
        t.e0 = x0; t.e1 = x1; t.eBusy = b; t.eReady = rdy;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge, check combinational
    // outputs before the next rising edge commits state.
    task automatic runVec(input vec_t v, input string tag);
        @(negedge clk);
        rst = v.rst; we = v.we; wa0 = v.wa0; wa1 = v.wa1; wd0 = v.wd0; wd1 = v.wd1;
        wclr = v.wclr; ren = v.ren; ra0 = v.ra0; ra1 = v.ra1;
        issue_valid = v.iv; issue_addr = v.ia;
        #1;
        chk({tag, ".rdata0"}, rdata[63:0], v.e0);
        chk({tag, ".rdata1"}, rdata[127:64], v.e1);
        chk({tag, ".rbusy"}, 64'(rbusy), 64'(v.eBusy));
        chk({tag, ".issue_ready"}, 64'(issue_ready), 64'(v.eReady));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl [9];

    initial begin
        rst = 1'b1; we = '0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; wclr = '0;
        ren = '0; ra0 = '0; ra1 = '0; issue_valid = 1'b0; issue_addr = '0;

        // rst, we, wa0, wa1, wd0, wd1, wclr, ren, ra0, ra1, iv, ia, e0, e1, eBusy, eReady
        tbl[0] = mk(0, 2'b01, 5, 0, 64'hDEAD_BEEF, 0, 2'b00, 2'b11, 5, 0, 0, 0, 64'hDEAD_BEEF, 0, 2'b00, 1);
        tbl[1] = mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b11, 5, 5, 0, 0, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 2'b00, 1);
        tbl[2] = mk(0, 2'b01, 0, 0, 64'h1234, 0, 2'b00, 2'b11, 0, 5, 0, 0, 0, 64'hDEAD_BEEF, 2'b00, 1);
        tbl[3] = mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 0, 5, 0, 0, 0, 0, 2'b00, 1);
        tbl[4] = mk(0, 2'b11, 7, 7, 64'h1111, 64'h2222, 2'b00, 2'b11, 7, 5, 0, 0, 64'h2222, 64'hDEAD_BEEF, 2'b00, 1);
        tbl[5] = mk(0, 2'b01, 5, 0, 64'h5555, 0, 2'b00, 2'b11, 7, 5, 0, 0, 64'h2222, 64'h5555, 2'b00, 1);
        tbl[6] = mk(0, 2'b11, 8, 9, 64'h8888, 64'h9999, 2'b00, 2'b11, 8, 9, 0, 0, 64'h8888, 64'h9999, 2'b00, 1);
        tbl[7] = mk(0, 2'b10, 0, 8, 0, 64'h7777, 2'b00, 2'b11, 8, 9, 0, 0, 64'h7777, 64'h9999, 2'b00, 1);
        tbl[8] = mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b11, 8, 5, 0, 0, 64'h7777, 64'h5555, 2'b00, 1);

        // Reset for two cycles; writes and issues during reset are ignored.
        for (int k = 0; k < 2; k++) begin
            runVec(mk(1, 2'b01, 9, 0, 64'hFFFF, 0, 2'b01, 2'b11, 5, 9, 1, 3, 0, 0, 2'b00, 0),
                   $sformatf("rst%0d", k));
        end
        for (int r = 0; r < 32; r++) begin
            runVec(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b11, 5'(r), 5'(31 - r), 0, 0, 0, 0, 2'b00, 1),
                   $sformatf("post_rst_r%0d", r));
        end
        chk("post_rst.err", 64'(err_underflow), 64'd0);

        for (int k = 0; k < 9; k++) begin
            runVec(tbl[k], $sformatf("tbl%0d", k));
        end

        // Two reservations on x4 retired by both ports in the same cycle.
        runVec(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b11, 4, 4, 1, 4, 0, 0, 2'b00, 1), "dual_i1");
        runVec(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b11, 4, 4, 1, 4, 0, 0, 2'b11, 1), "dual_i2");
        runVec(mk(0, 2'b11, 4, 4, 64'h41, 64'h42, 2'b11, 2'b11, 4, 4, 0, 4, 64'h42, 64'h42, 2'b00, 1), "dual_clr");
        runVec(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b11, 4, 4, 0, 4, 64'h42, 64'h42, 2'b00, 1), "dual_after");
        chk("dual.err", 64'(err_underflow), 64'd0);

        // Fill x3 to saturation, then issue alongside a clear.
        runVec(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 3, 0, 1, 3, 0, 0, 2'b00, 1), "sat_i1");
        runVec(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 3, 0, 1, 3, 0, 0, 2'b01, 1), "sat_i2");
        runVec(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 3, 0, 1, 3, 0, 0, 2'b01, 1), "sat_i3");
        runVec(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 3, 0, 1, 3, 0, 0, 2'b01, 0), "sat_i4_full");
        runVec(mk(0, 2'b01, 3, 0, 64'h30, 0, 2'b01, 2'b01, 3, 0, 1, 3, 64'h30, 0, 2'b01, 1), "sat_i4_clr");
        runVec(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 3, 0, 1, 3, 64'h30, 0, 2'b01, 0), "sat_still_full");

        // Drain x3; busy drops in the cycle of the last clear.
        runVec(mk(0, 2'b01, 3, 0, 64'h31, 0, 2'b01, 2'b01, 3, 0, 0, 0, 64'h31, 0, 2'b01, 1), "drain1");
        runVec(mk(0, 2'b01, 3, 0, 64'h32, 0, 2'b01, 2'b01, 3, 0, 0, 0, 64'h32, 0, 2'b01, 1), "drain2");
        runVec(mk(0, 2'b01, 3, 0, 64'h33, 0, 2'b01, 2'b01, 3, 0, 0, 0, 64'h33, 0, 2'b00, 1), "drain3");
        chk("drain3.err", 64'(err_underflow), 64'd0);
        runVec(mk(0, 2'b01, 3, 0, 64'h34, 0, 2'b01, 2'b01, 3, 0, 0, 0, 64'h34, 0, 2'b00, 1), "extra_clr");
        chk("extra_clr.err_before_edge", 64'(err_underflow), 64'd0);
        runVec(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 3, 0, 1, 3, 64'h34, 0, 2'b00, 1), "uf_reissue");
        chk("uf.err_set", 64'(err_underflow), 64'd1);
        runVec(mk(0, 2'b00, 3, 0, 0, 0, 2'b01, 2'b01, 3, 0, 0, 0, 64'h34, 0, 2'b01, 1), "wclr_no_we");
        runVec(mk(0, 2'b01, 3, 0, 0, 0, 2'b01, 2'b01, 3, 0, 0, 0, 0, 0, 2'b00, 1), "final_clr");
        runVec(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 3, 0, 0, 0, 0, 0, 2'b00, 1), "x3_idle");
        chk("uf.err_sticky", 64'(err_underflow), 64'd1);

        // Reset with two writes pending on x9.
        runVec(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b11, 9, 9, 1, 9, 64'h9999, 64'h9999, 2'b00, 1), "mid_i1");
        runVec(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b11, 9, 9, 1, 9, 64'h9999, 64'h9999, 2'b11, 1), "mid_i2");
        runVec(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b11, 9, 9, 0, 9, 64'h9999, 64'h9999, 2'b11, 1), "mid_busy");
        chk("mid.err_before_rst", 64'(err_underflow), 64'd1);
        runVec(mk(1, 2'b01, 9, 0, 64'hFFFF, 0, 2'b01, 2'b11, 9, 9, 1, 9, 0, 0, 2'b00, 0), "mid_rst");
        runVec(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b11, 9, 5, 0, 9, 0, 0, 2'b00, 1), "mid_after");
        chk("mid.err_cleared", 64'(err_underflow), 64'd0);
        runVec(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b11, 8, 4, 0, 3, 0, 0, 2'b00, 1), "mid_after2");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
